// File: rtl/canv_pkg.sv
// canv_pkg: shared constants and slice helpers for the layered canvas AGU.
package canv_pkg;

    // Field order inside a {y,x} or {h,w} pair: x / w live in the low half.
    localparam int FLD_X = 0;
    localparam int FLD_Y = 1;
    localparam int FLD_W = 0;
    localparam int FLD_H = 1;

    // Values substituted when software leaves a scale or size field at zero.
    localparam int DEF_SCALE = 1;
    localparam int DEF_SIZE  = 1;

    // Low bit of element idx in a packed vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // Low bit of field fld inside one 2*cordw pair.
    function automatic int field_lo(input int fld, input int cordw);
        return fld * cordw;
    endfunction

endpackage

// File: rtl/canv_layer_agu_ch.sv
// canv_layer_agu_ch: one canvas layer -- frame-latched shadow config,
// canvas coordinate / scale counters and the two-stage address pipeline.
module canv_layer_agu_ch
    import canv_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int ADDRW    = 14,
    parameter int BMAP_LAT = 4,
    parameter int PIX_IDW  = 5,
    parameter int SHIFTW   = 3
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic signed [CORDW-1:0] dx,
    input  logic signed [CORDW-1:0] dy,
    input  logic                    layer_en,
    input  logic [ADDRW-1:0]        addr_base,
    input  logic [SHIFTW-1:0]       addr_shift,
    input  logic [2*CORDW-1:0]      win_start,
    input  logic [2*CORDW-1:0]      win_end,
    input  logic [2*CORDW-1:0]      scale,
    input  logic [2*CORDW-1:0]      scroll,
    input  logic [2*CORDW-1:0]      canv_size,
    output logic [ADDRW-1:0]        addr,
    output logic [PIX_IDW-1:0]      pix_id,
    output logic                    paint
);

    localparam int LAW = ADDRW + PIX_IDW;
    localparam int XL  = field_lo(FLD_X, CORDW);
    localparam int YL  = field_lo(FLD_Y, CORDW);
    localparam int WL  = field_lo(FLD_W, CORDW);
    localparam int HL  = field_lo(FLD_H, CORDW);

    // Fetch runs BMAP_LAT-1 pixels ahead of the window; paint only 2 ahead,
    // since paint must line up with data after the external VRAM/CLUT stages.
    localparam logic signed [CORDW-1:0] LAT_FETCH = CORDW'(BMAP_LAT - 1);
    localparam logic signed [CORDW-1:0] LAT_PAINT = CORDW'(2);
    localparam logic [CORDW-1:0]        C_ONE     = CORDW'(1);

    // Shadow configuration
    logic                    r_en;
    logic [ADDRW-1:0]        r_base;
    logic [SHIFTW-1:0]       r_shift;
    logic signed [CORDW-1:0] r_ws_x, r_ws_y, r_we_x, r_we_y;
    logic [CORDW-1:0]        r_sc_x, r_sc_y;
    logic [CORDW-1:0]        r_scr_x, r_scr_y;
    logic [CORDW-1:0]        r_cw, r_ch;

    // Frame-start follow-up and line initialisation
    logic                    r_fs_d1, r_fs_d2;
    logic [LAW-1:0]          r_line_init;

    // Counters
    logic [CORDW-1:0]        r_cx, r_cy, r_cnt_x, r_cnt_y;
    logic [LAW-1:0]          r_line_addr, r_line_addr_sv;

    // Pipeline
    logic [LAW-1:0]          r_pix;
    logic                    r_paint1;
    logic [ADDRW-1:0]        r_addr;
    logic [PIX_IDW-1:0]      r_pix_id;
    logic                    r_paint;

    // Derived combinational terms
    logic [CORDW-1:0]        w_sc_x, w_sc_y, w_sc_x_m1, w_sc_y_m1;
    logic [CORDW-1:0]        w_w, w_h;
    logic [CORDW-1:0]        w_cx_inc, w_cy_inc;
    logic signed [CORDW-1:0] w_vx_lo, w_vx_hi, w_px_lo, w_px_hi;
    logic                    w_win_ok, w_paint_y, w_vram_x, w_paint_x;
    logic                    w_adv_y, w_step;
    logic [LAW-1:0]          w_w_ext;
    logic [2*CORDW-1:0]      w_init_prod;
    logic [LAW-1:0]          w_pix_shift;
    logic [PIX_IDW-1:0]      w_id_mask;

    // Zero scale / size fields behave as one.
    assign w_sc_x    = (r_sc_x == '0) ? CORDW'(DEF_SCALE) : r_sc_x;
    assign w_sc_y    = (r_sc_y == '0) ? CORDW'(DEF_SCALE) : r_sc_y;
    assign w_sc_x_m1 = w_sc_x - C_ONE;
    assign w_sc_y_m1 = w_sc_y - C_ONE;
    assign w_w       = (r_cw == '0) ? CORDW'(DEF_SIZE) : r_cw;
    assign w_h       = (r_ch == '0) ? CORDW'(DEF_SIZE) : r_ch;
    assign w_cx_inc  = r_cx + C_ONE;
    assign w_cy_inc  = r_cy + C_ONE;
    assign w_w_ext   = LAW'(w_w);

    assign w_vx_lo   = r_ws_x - LAT_FETCH;
    assign w_vx_hi   = r_we_x - LAT_FETCH;
    assign w_px_lo   = r_ws_x - LAT_PAINT;
    assign w_px_hi   = r_we_x - LAT_PAINT;

    // An empty window on either axis freezes the counters entirely.
    assign w_win_ok  = (r_we_x > r_ws_x) && (r_we_y > r_ws_y);
    assign w_paint_y = (dy >= r_ws_y) && (dy < r_we_y);
    assign w_vram_x  = (dx >= w_vx_lo) && (dx < w_vx_hi);
    assign w_paint_x = (dx >= w_px_lo) && (dx < w_px_hi);
    // The first window line uses the frame's initial row, so advancing
    // starts strictly after win_start_y.
    assign w_adv_y   = w_win_ok && (dy > r_ws_y) && (dy < r_we_y);
    assign w_step    = w_win_ok && w_paint_y && w_vram_x;

    assign w_init_prod = {{CORDW{1'b0}}, r_scr_y} * {{CORDW{1'b0}}, w_w};
    assign w_pix_shift = r_pix >> r_shift;

    // Pixel-in-word mask: the low 'shift' bits of the pixel index.
    for (genvar gi = 0; gi < PIX_IDW; gi++) begin : g_mask
        assign w_id_mask[gi] = ({{(32-SHIFTW){1'b0}}, r_shift} > 32'(gi));
    end

    // Latch the whole layer configuration at frame start for tear-free updates.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_en    <= 1'b0;
            r_base  <= '0;
            r_shift <= '0;
            r_ws_x  <= '0;
            r_ws_y  <= '0;
            r_we_x  <= '0;
            r_we_y  <= '0;
            r_sc_x  <= '0;
            r_sc_y  <= '0;
            r_scr_x <= '0;
            r_scr_y <= '0;
            r_cw    <= '0;
            r_ch    <= '0;
        end else if (frame_start) begin
            r_en    <= layer_en;
            r_base  <= addr_base;
            r_shift <= addr_shift;
            r_ws_x  <= win_start[XL +: CORDW];
            r_ws_y  <= win_start[YL +: CORDW];
            r_we_x  <= win_end[XL +: CORDW];
            r_we_y  <= win_end[YL +: CORDW];
            r_sc_x  <= scale[XL +: CORDW];
            r_sc_y  <= scale[YL +: CORDW];
            r_scr_x <= scroll[XL +: CORDW];
            r_scr_y <= scroll[YL +: CORDW];
            r_cw    <= canv_size[WL +: CORDW];
            r_ch    <= canv_size[HL +: CORDW];
        end
    end

    // Compute scroll_y*w the cycle after frame start, once shadow is valid.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_fs_d1     <= 1'b0;
            r_fs_d2     <= 1'b0;
            r_line_init <= '0;
        end else begin
            r_fs_d1 <= frame_start;
            r_fs_d2 <= r_fs_d1;
            if (r_fs_d1) begin
                r_line_init <= LAW'(w_init_prod);
            end
        end
    end

    // Vertical state: canvas row, row repeat counter and row base address.
    // The line-address load two cycles after frame start never coincides
    // with a vertical advance because the window starts lines later.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_cy           <= '0;
            r_cnt_y        <= '0;
            r_line_addr    <= '0;
            r_line_addr_sv <= '0;
        end else if (frame_start) begin
            r_cy    <= scroll[YL +: CORDW];
            r_cnt_y <= '0;
        end else if (r_fs_d2) begin
            r_line_addr    <= r_line_init;
            r_line_addr_sv <= r_line_init;
        end else if (line_start && w_adv_y) begin
            if (r_cnt_y == w_sc_y_m1) begin
                r_cnt_y <= '0;
                if (w_cy_inc == w_h) begin
                    r_cy           <= '0;
                    r_line_addr    <= '0;
                    r_line_addr_sv <= '0;
                end else begin
                    r_cy           <= w_cy_inc;
                    r_line_addr    <= r_line_addr_sv + w_w_ext;
                    r_line_addr_sv <= r_line_addr_sv + w_w_ext;
                end
            end else begin
                r_cnt_y     <= r_cnt_y + C_ONE;
                r_line_addr <= r_line_addr_sv;
            end
        end
    end

    // Horizontal state: canvas column and pixel repeat counter.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_cx    <= '0;
            r_cnt_x <= '0;
        end else if (frame_start) begin
            r_cx    <= scroll[XL +: CORDW];
            r_cnt_x <= '0;
        end else if (line_start) begin
            r_cx    <= r_scr_x;
            r_cnt_x <= '0;
        end else if (w_step) begin
            if (r_cnt_x == w_sc_x_m1) begin
                r_cnt_x <= '0;
                r_cx    <= (w_cx_inc == w_w) ? '0 : w_cx_inc;
            end else begin
                r_cnt_x <= r_cnt_x + C_ONE;
            end
        end
    end

    // Stage 1: linear canvas pixel index and early paint qualifier.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_pix    <= '0;
            r_paint1 <= 1'b0;
        end else begin
            r_pix    <= r_line_addr + LAW'(r_cx);
            r_paint1 <= r_en && w_paint_y && w_paint_x;
        end
    end

    // Stage 2: word address and pixel-in-word index.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_addr   <= '0;
            r_pix_id <= '0;
            r_paint  <= 1'b0;
        end else begin
            r_addr   <= r_base + ADDRW'(w_pix_shift);
            r_pix_id <= r_pix[PIX_IDW-1:0] & w_id_mask;
            r_paint  <= r_paint1;
        end
    end

    assign addr   = r_addr;
    assign pix_id = r_pix_id;
    assign paint  = r_paint;

endmodule

// File: rtl/canv_layer_agu.sv
// canv_layer_agu: LAYERS independent canvas address generators sharing one
// display timing source; each layer owns one slice of every packed port.
module canv_layer_agu
    import canv_pkg::*;
#(
    parameter int LAYERS   = 2,
    parameter int CORDW    = 16,
    parameter int WORD     = 32,
    parameter int ADDRW    = 14,
    parameter int BMAP_LAT = 4,
    parameter int PIX_IDW  = $clog2(WORD),
    parameter int SHIFTW   = 3
) (
    input  logic                        clk_pix,
    input  logic                        rst_pix,
    input  logic                        frame_start,
    input  logic                        line_start,
    input  logic signed [CORDW-1:0]     dx,
    input  logic signed [CORDW-1:0]     dy,
    input  logic [LAYERS-1:0]           layer_en,
    input  logic [LAYERS*ADDRW-1:0]     addr_base,
    input  logic [LAYERS*SHIFTW-1:0]    addr_shift,
    input  logic [LAYERS*2*CORDW-1:0]   win_start,
    input  logic [LAYERS*2*CORDW-1:0]   win_end,
    input  logic [LAYERS*2*CORDW-1:0]   scale,
    input  logic [LAYERS*2*CORDW-1:0]   scroll,
    input  logic [LAYERS*2*CORDW-1:0]   canv_size,
    output logic [LAYERS*ADDRW-1:0]     addr,
    output logic [LAYERS*PIX_IDW-1:0]   pix_id,
    output logic [LAYERS-1:0]           paint
);

    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
        localparam int A_LO = slice_lo(gi, ADDRW);
        localparam int S_LO = slice_lo(gi, SHIFTW);
        localparam int P_LO = slice_lo(gi, 2*CORDW);
        localparam int I_LO = slice_lo(gi, PIX_IDW);

        canv_layer_agu_ch #(
            .CORDW    (CORDW),
            .ADDRW    (ADDRW),
            .BMAP_LAT (BMAP_LAT),
            .PIX_IDW  (PIX_IDW),
            .SHIFTW   (SHIFTW)
        ) u_ch (
            .clk_pix     (clk_pix),
            .rst_pix     (rst_pix),
            .frame_start (frame_start),
            .line_start  (line_start),
            .dx          (dx),
            .dy          (dy),
            .layer_en    (layer_en[gi]),
            .addr_base   (addr_base[A_LO +: ADDRW]),
            .addr_shift  (addr_shift[S_LO +: SHIFTW]),
            .win_start   (win_start[P_LO +: 2*CORDW]),
            .win_end     (win_end[P_LO +: 2*CORDW]),
            .scale       (scale[P_LO +: 2*CORDW]),
            .scroll      (scroll[P_LO +: 2*CORDW]),
            .canv_size   (canv_size[P_LO +: 2*CORDW]),
            .addr        (addr[A_LO +: ADDRW]),
            .pix_id      (pix_id[I_LO +: PIX_IDW]),
            .paint       (paint[gi])
        );
    end

endmodule

// File: tb/tb_canv_layer_agu.sv
// tb_canv_layer_agu: directed frames for a two-layer AGU with a scoreboard
// of expected per-cycle outputs derived from closed-form canvas coordinates.
module tb_canv_layer_agu;

    localparam int NL = 2;
    localparam int CW = 16;
    localparam int AW = 14;
    localparam int IW = 5;
    localparam int SW = 3;

    logic                   clk_pix = 1'b0;
    logic                   rst_pix;
    logic                   frame_start;
    logic                   line_start;
    logic signed [CW-1:0]   dx, dy;
    logic [NL-1:0]          layer_en;
    logic [NL*AW-1:0]       addr_base;
    logic [NL*SW-1:0]       addr_shift;
    logic [NL*2*CW-1:0]     win_start, win_end, scale, scroll, canv_size;
    logic [NL*AW-1:0]       addr;
    logic [NL*IW-1:0]       pix_id;
    logic [NL-1:0]          paint;

    canv_layer_agu #(
        .LAYERS(NL), .CORDW(CW), .WORD(32), .ADDRW(AW),
        .BMAP_LAT(4), .PIX_IDW(IW), .SHIFTW(SW)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .frame_start(frame_start), .line_start(line_start),
        .dx(dx), .dy(dy), .layer_en(layer_en),
        .addr_base(addr_base), .addr_shift(addr_shift),
        .win_start(win_start), .win_end(win_end),
        .scale(scale), .scroll(scroll), .canv_size(canv_size),
        .addr(addr), .pix_id(pix_id), .paint(paint)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int en, base, shift;
        int wsx, wsy, wex, wey;
        int scx, scy, srx, sry, w, h;
    } lcfg_t;

    typedef struct packed {
        logic [NL-1:0]    p;
        logic [NL-1:0]    care;
        logic [NL*AW-1:0] a;
        logic [NL*IW-1:0] id;
    } exp_t;

    lcfg_t cfg [NL];   // what is driven on the inputs
    lcfg_t shd [NL];   // what the design should have latched
    exp_t  q [$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input int l, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s layer %0d: got 0x%0h expected 0x%0h", tag, l, obs, expv);
        end
    endtask

    task automatic apply_cfg();
        for (int l = 0; l < NL; l++) begin
            layer_en[l]                = cfg[l].en[0];
            addr_base[l*AW +: AW]      = AW'(cfg[l].base);
            addr_shift[l*SW +: SW]     = SW'(cfg[l].shift);
            win_start[l*2*CW +: 2*CW]  = {CW'(cfg[l].wsy), CW'(cfg[l].wsx)};
            win_end[l*2*CW +: 2*CW]    = {CW'(cfg[l].wey), CW'(cfg[l].wex)};
            scale[l*2*CW +: 2*CW]      = {CW'(cfg[l].scy), CW'(cfg[l].scx)};
            scroll[l*2*CW +: 2*CW]     = {CW'(cfg[l].sry), CW'(cfg[l].srx)};
            canv_size[l*2*CW +: 2*CW]  = {CW'(cfg[l].h),   CW'(cfg[l].w)};
        end
    endtask

    task automatic set_layer(input int l, input int en, input int base, input int shift,
                             input int wsx, input int wsy, input int wex, input int wey,
                             input int scx, input int scy, input int srx, input int sry,
                             input int w, input int h);
        cfg[l].en = en;   cfg[l].base = base; cfg[l].shift = shift;
        cfg[l].wsx = wsx; cfg[l].wsy = wsy;   cfg[l].wex = wex; cfg[l].wey = wey;
        cfg[l].scx = scx; cfg[l].scy = scy;   cfg[l].srx = srx; cfg[l].sry = sry;
        cfg[l].w = w;     cfg[l].h = h;
        apply_cfg();
    endtask

    task automatic clear_shadow();
        for (int l = 0; l < NL; l++) begin
            shd[l] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end
    endtask

    // Expected outputs two cycles after display position (x,y) for layer l.
    task automatic model(input int l, input int x, input int y,
                         output logic p, output logic care,
                         output logic [AW-1:0] a, output logic [IW-1:0] id);
        int sx, sy, w, h, steps, cx, cy, pix;
        bit win_ok, py;
        sx = (shd[l].scx == 0) ? 1 : shd[l].scx;
        sy = (shd[l].scy == 0) ? 1 : shd[l].scy;
        w  = (shd[l].w == 0) ? 1 : shd[l].w;
        h  = (shd[l].h == 0) ? 1 : shd[l].h;
        win_ok = (shd[l].wex > shd[l].wsx) && (shd[l].wey > shd[l].wsy);
        py     = (y >= shd[l].wsy) && (y < shd[l].wey);
        p      = (shd[l].en != 0) && py && (x >= shd[l].wsx - 2) && (x < shd[l].wex - 2);
        care   = win_ok && py && (x >= shd[l].wsx - 3) && (x < shd[l].wex - 2);
        steps  = x - (shd[l].wsx - 3);
        if (steps < 0) steps = 0;
        if (steps > shd[l].wex - shd[l].wsx) steps = shd[l].wex - shd[l].wsx;
        cx  = (shd[l].srx + steps / sx) % w;
        cy  = (y >= shd[l].wsy) ? (shd[l].sry + (y - shd[l].wsy) / sy) % h : 0;
        pix = cy * w + cx;
        a   = AW'(shd[l].base + (pix >> shd[l].shift));
        id  = IW'(pix & ((1 << shd[l].shift) - 1));
    endtask

    task automatic compare_front();
        exp_t e;
        e = q.pop_front();
        for (int l = 0; l < NL; l++) begin
            check("paint", l, int'(paint[l]), int'(e.p[l]));
            if (e.care[l]) begin
                check("addr",   l, int'(addr[l*AW +: AW]),   int'(e.a[l*AW +: AW]));
                check("pix_id", l, int'(pix_id[l*IW +: IW]), int'(e.id[l*IW +: IW]));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int l = 0; l < NL; l++) begin
            check({tag, "_paint"},  l, int'(paint[l]), 0);
            check({tag, "_addr"},   l, int'(addr[l*AW +: AW]), 0);
            check({tag, "_pix_id"}, l, int'(pix_id[l*IW +: IW]), 0);
        end
    endtask

    // One display line, dx = -8..11; line_start (and optionally frame_start)
    // on the first pixel; optional one-cycle reset at pixel rst_x.
    task automatic run_line(input int y, input bit fs, input int rst_x);
        for (int x = -8; x <= 11; x++) begin
            dx = CW'(x);
            dy = CW'(y);
            line_start  = (x == -8);
            frame_start = fs && (x == -8);
            if (x == rst_x) begin
                rst_pix = 1'b1;
                @(posedge clk_pix);
                #1;
                rst_pix = 1'b0;
                q.delete();
                clear_shadow();
                check_all_zero("rst_mid");
            end else begin
                exp_t e;
                for (int l = 0; l < NL; l++) begin
                    logic p, c;
                    logic [AW-1:0] a;
                    logic [IW-1:0] id;
                    model(l, x, y, p, c, a, id);
                    e.p[l] = p;
                    e.care[l] = c;
                    e.a[l*AW +: AW] = a;
                    e.id[l*IW +: IW] = id;
                end
                q.push_back(e);
                if (frame_start) begin
                    for (int l = 0; l < NL; l++) shd[l] = cfg[l];
                end
                @(posedge clk_pix);
                #1;
                if (q.size() >= 2) compare_front();
            end
        end
    endtask

    // Frame of lines dy = -3..6; optional mid-frame reset and mid-frame
    // change of layer 0 base.
    task automatic run_frame(input int rst_y, input int rst_x,
                             input int chg_y, input int chg_base);
        for (int y = -3; y <= 6; y++) begin
            if (y == chg_y) begin
                cfg[0].base = chg_base;
                apply_cfg();
            end
            run_line(y, (y == -3), (y == rst_y) ? rst_x : 99);
        end
    endtask

    initial begin
        rst_pix = 1'b1;
        frame_start = 1'b0;
        line_start = 1'b0;
        dx = '0;
        dy = '0;
        clear_shadow();
        for (int l = 0; l < NL; l++) cfg[l] = shd[l];
        apply_cfg();
        // Layer 0: 8x4 canvas, 4 pixels per word; layer 1: 4x4 canvas scaled {2,3}.
        set_layer(0, 1, 'h100, 2, 0, 0, 8, 4, 1, 1, 0, 0, 8, 4);
        set_layer(1, 1, 'h200, 1, 0, 0, 12, 6, 3, 2, 0, 0, 4, 4);
        repeat (3) @(posedge clk_pix);
        #1;
        check_all_zero("reset");
        rst_pix = 1'b0;

        // Before any frame_start the layers must stay dark.
        run_line(-5, 1'b0, 99);

        // Frame 1: basic addressing and scaling.
        run_frame(99, 99, 99, 0);

        // Frame 2: scroll with wrap on layer 0, zero scale/height on layer 1,
        // mid-frame base change on layer 0 that must not take effect yet.
        set_layer(0, 1, 'h000, 0, 0, 0, 8, 4, 1, 1, 6, 3, 8, 4);
        set_layer(1, 1, 'h010, 0, 2, 1, 10, 5, 0, 0, 1, 0, 4, 0);
        run_frame(99, 99, 2, 'h200);

        // Frame 3: new base now latched.
        run_frame(99, 99, 99, 0);

        // Frame 4: only layer 1 enabled with its own window; reset mid-line.
        set_layer(0, 0, 'h100, 2, 0, 0, 8, 4, 1, 1, 0, 0, 8, 4);
        set_layer(1, 1, 'h040, 0, 4, 2, 7, 4, 1, 1, 0, 0, 4, 4);
        run_frame(3, 0, 99, 0);

        // Frame 5: layer 0 restored; layer 1 with an empty horizontal window.
        set_layer(0, 1, 'h100, 2, 0, 0, 8, 4, 1, 1, 0, 0, 8, 4);
        set_layer(1, 1, 'h040, 0, 5, 0, 5, 4, 1, 1, 0, 0, 4, 4);
        run_frame(99, 99, 99, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
